mac_slot_scheduler: RTL and testbench
=====================================

Name: mac_slot_scheduler

Overview:
Slotted-ALOHA access controller for the tag's backscatter modulator. It takes a transmit request and draws a random slot offset from an internal 16-bit LFSR masked to the current window exponent Q. It counts slot boundaries, then issues a single modulator start pulse. It adapts Q (increase on collision/timeout, decrease on success), retries up to a limit, and reports done or fail to the control logic above.

Parameters:
LFSR_SEED, 16'h4C06, LFSR reset value; a value of 0 is replaced by 16'h0001.
Q_INIT, 2, Q value after reset.
Q_MIN, 0, lower saturation bound for Q.
Q_MAX, 6, upper saturation bound for Q; must be ≤15.
MAX_RETRY, 7, number of failed attempts before fail is raised; range 1..15.
FB_TIMEOUT, 8, slot_ticks to wait for feedback before declaring collision; must be ≥1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  synchronous run enable; low forces IDLE and keeps Q
req  in  1  1-cycle transmit request pulse
slot_tick  in  1  1-cycle pulse marking each slot boundary
mod_busy  in  1  modulator active flag
fb_valid  in  1  1-cycle feedback strobe from downlink decoder
fb_ack  in  1  feedback value qualified by fb_valid: 1=ack, 0=nack
mod_start  out  1  1-cycle modulator start pulse
busy  out  1  high whenever state ≠ IDLE
done  out  1  1-cycle success pulse
fail  out  1  1-cycle retry-exhausted pulse
q_cur  out  4  current window exponent
retry_cnt  out  4  failed attempts in the current request

Behaviour:
- Reset: state=IDLE, lfsr=LFSR_SEED (or 1), q_cur=Q_INIT, retry_cnt=0, slot_cnt=0, fb_timer=0. All pulse outputs and busy are 0.
- LFSR: free-running, one shift every clk while rst_n is high, including during IDLE and while enable=0. Polynomial x^16+x^14+x^13+x^11+1. Update: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- All outputs are registered.
- IDLE: req=1 and enable=1 -> DRAW on the next edge. req is ignored in every other state.
- DRAW (1 cycle): slot_cnt <= lfsr & ((1<<q_cur)-1). With q_cur=0 the result is 0. Next state WAIT_SLOT.
- WAIT_SLOT:
  - On slot_tick with slot_cnt=0: mod_start=1 in the following cycle, state -> TX.
  - On slot_tick with slot_cnt>0: slot_cnt decrements.
  - Without slot_tick: hold.
  - Minimum latency: req to mod_start is 2 cycles plus the wait for the first slot_tick.
- TX:
  - mod_busy is ignored in the cycle in which mod_start is high.
  - From the next cycle on, mod_busy=0 -> WAIT_FB with fb_timer=0.
  - A modulator that never asserts busy therefore yields a TX of 2 cycles.
- WAIT_FB:
  - fb_valid&fb_ack -> success: done=1 for 1 cycle; q_cur=max(q_cur-1,Q_MIN); retry_cnt=0; state -> IDLE.
  - fb_valid&~fb_ack, or slot_tick when fb_timer=FB_TIMEOUT-1 -> collision: q_cur=min(q_cur+1,Q_MAX).
  - If retry_cnt+1=MAX_RETRY on a collision: fail=1, retry_cnt=0, state -> IDLE.
  - Otherwise on a collision: retry_cnt increments and state -> DRAW.
  - Otherwise, slot_tick increments fb_timer.
  - fb_valid and slot_tick in the same cycle: fb_valid takes priority and the tick is not counted.
- fb_valid outside WAIT_FB is ignored.
- enable=0 in any state: next state IDLE, retry_cnt=0, no done/fail/mod_start pulses are issued; q_cur and lfsr are kept.
  - If enable falls in the same cycle that mod_start is being driven, that pulse still completes. No new pulse is generated.
- Async reset mid-operation: immediate return to reset values. A mod_start in flight is cleared.
- done and fail are never high together. Each is high for exactly one cycle per request.

Test Plan:
- Q_INIT=0; req, then slot_tick 5 cycles later -> mod_start high exactly 1 cycle after that tick. Then mod_busy high 10 cycles, then fb_valid=1, fb_ack=1 -> done 1 cycle, q_cur stays 0, busy=0.
- Q_INIT=2; req; log the lfsr[1:0] masked value R in DRAW against the bench LFSR model -> mod_start follows the (R+1)th slot_tick. Repeat 200 requests -> R histogram covers 0..3.
- Q_INIT=2, FB_TIMEOUT=8; after TX, no feedback -> on the 8th slot_tick q_cur=3, retry_cnt=1, DRAW re-entered. Simultaneous fb_valid with the 8th tick, fb_ack=1 -> done instead.
- MAX_RETRY=7, Q_INIT=4; nack every attempt -> q_cur 5,6,6,6,… (saturates at Q_MAX=6). fail pulses 1 cycle on the 7th nack, retry_cnt=0, and no 8th mod_start.
- Q_MIN=0, q_cur=1; ack -> q_cur=0. Next ack -> q_cur stays 0. req while busy=1 -> ignored, no extra mod_start.
- rst_n low asynchronously during TX -> all outputs 0 and q_cur=Q_INIT before the next clk edge. In a separate run, enable low in WAIT_SLOT -> IDLE next cycle, q_cur unchanged, no mod_start.

Source files
------------

// File: rtl/mac_slot_scheduler_if.sv
// Handshake bundle between the slotted-ALOHA scheduler and its environment.
// master: the control/modem side that drives requests, ticks and feedback.
// slave : the scheduler itself.
// Signals:
//   enable, req, slot_tick, mod_busy, fb_valid, fb_ack : master -> slave
//   mod_start, busy, done, fail, q_cur, retry_cnt      : slave -> master
//   state_dbg                                           : FSM state for checkers
// Handshake: req, slot_tick, fb_valid, mod_start, done and fail are single-cycle
// strobes sampled on the rising clock edge; fb_ack is only meaningful while
// fb_valid is high; no ready back-pressure exists, a strobe that arrives in a
// state that does not consume it is dropped.
interface mac_slot_scheduler_if;
  logic       enable;
  logic       req;
  logic       slot_tick;
  logic       mod_busy;
  logic       fb_valid;
  logic       fb_ack;
  logic       mod_start;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] q_cur;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  modport master (
    output enable, req, slot_tick, mod_busy, fb_valid, fb_ack,
    input  mod_start, busy, done, fail, q_cur, retry_cnt, state_dbg
  );

  modport slave (
    input  enable, req, slot_tick, mod_busy, fb_valid, fb_ack,
    output mod_start, busy, done, fail, q_cur, retry_cnt, state_dbg
  );
endinterface

// File: rtl/mac_slot_scheduler.sv
// Slotted-ALOHA access controller for the backscatter modulator.
// A request draws a random slot offset (free-running LFSR masked to 2^Q-1),
// counts slot boundaries down to zero, fires one modulator start pulse, then
// waits for ack/nack feedback (or a slot-count timeout). Q shrinks on success
// and grows on collision; after MAX_RETRY collisions the request fails.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : scheduler side of mac_slot_scheduler_if (all outputs registered)
module mac_slot_scheduler #(
  parameter logic [15:0] LFSR_SEED  = 16'h4C06,
  parameter int          Q_INIT     = 2,
  parameter int          Q_MIN      = 0,
  parameter int          Q_MAX      = 6,
  parameter int          MAX_RETRY  = 7,
  parameter int          FB_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_slot_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAW      = 3'd1,
    S_WAIT_SLOT = 3'd2,
    S_TX        = 3'd3,
    S_WAIT_FB   = 3'd4
  } state_e;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]  Q_INIT_L   = 4'(Q_INIT);
  localparam logic [3:0]  Q_MIN_L    = 4'(Q_MIN);
  localparam logic [3:0]  Q_MAX_L    = 4'(Q_MAX);
  localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY - 1);
  localparam logic [15:0] FB_LAST    = 16'(FB_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] slot_cnt_q, slot_cnt_d;
  logic [15:0] fb_timer_q, fb_timer_d;
  logic [3:0]  q_q, q_d;
  logic [3:0]  retry_q, retry_d;
  logic        mod_start_q, mod_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic success, collision, exhausted, slot_hit;

  // fb_valid wins over a simultaneous slot_tick, so the timeout only fires
  // on a tick with no feedback strobe present.
  assign success   = (state_q == S_WAIT_FB) && bus.fb_valid && bus.fb_ack;
  assign collision = (state_q == S_WAIT_FB) &&
                     ((bus.fb_valid && !bus.fb_ack) ||
                      (!bus.fb_valid && bus.slot_tick && (fb_timer_q == FB_LAST)));
  assign exhausted = (retry_q == RETRY_LAST);
  assign slot_hit  = bus.slot_tick && (slot_cnt_q == 16'd0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      slot_cnt_q  <= 16'd0;
      fb_timer_q  <= 16'd0;
      q_q         <= Q_INIT_L;
      retry_q     <= 4'd0;
      mod_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      slot_cnt_q  <= slot_cnt_d;
      fb_timer_q  <= fb_timer_d;
      q_q         <= q_d;
      retry_q     <= retry_d;
      mod_start_q <= mod_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (bus.req) state_d = S_DRAW;
        S_DRAW:      state_d = S_WAIT_SLOT;
        S_WAIT_SLOT: if (slot_hit) state_d = S_TX;
        // mod_busy is not trusted in the cycle the start pulse is on the wire.
        S_TX:        if (!mod_start_q && !bus.mod_busy) state_d = S_WAIT_FB;
        S_WAIT_FB: begin
          if (success)        state_d = S_IDLE;
          else if (collision) state_d = exhausted ? S_IDLE : S_DRAW;
        end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    slot_cnt_d  = slot_cnt_q;
    fb_timer_d  = fb_timer_q;
    q_d         = q_q;
    retry_d     = retry_q;
    mod_start_d = 1'b0;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    busy_d      = (state_d != S_IDLE);
    if (!bus.enable) begin
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_DRAW:      slot_cnt_d = lfsr_q & ~(16'hFFFF << q_q);
        S_WAIT_SLOT: begin
          if (slot_hit)           mod_start_d = 1'b1;
          else if (bus.slot_tick) slot_cnt_d  = slot_cnt_q - 16'd1;
        end
        S_TX:        fb_timer_d = 16'd0;
        S_WAIT_FB: begin
          if (success) begin
            done_d  = 1'b1;
            q_d     = (q_q > Q_MIN_L) ? q_q - 4'd1 : Q_MIN_L;
            retry_d = 4'd0;
          end else if (collision) begin
            q_d = (q_q < Q_MAX_L) ? q_q + 4'd1 : Q_MAX_L;
            if (exhausted) begin
              fail_d  = 1'b1;
              retry_d = 4'd0;
            end else begin
              retry_d = retry_q + 4'd1;
            end
          end else if (bus.slot_tick) begin
            fb_timer_d = fb_timer_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mod_start = mod_start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.q_cur     = q_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mac_slot_scheduler.sv
`timescale 1ns/1ps
module tb_mac_slot_scheduler;
  localparam logic [15:0] SEED = 16'h4C06;
  localparam int QI   = 2;
  localparam int QMIN = 0;
  localparam int QMAX = 6;
  localparam int MAXR = 7;
  localparam int FBT  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mac_slot_scheduler_if bus();

  mac_slot_scheduler #(
    .LFSR_SEED(SEED), .Q_INIT(QI), .Q_MIN(QMIN), .Q_MAX(QMAX),
    .MAX_RETRY(MAXR), .FB_TIMEOUT(FBT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Free-running LFSR, shifted on every clock while out of reset.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int q_exp     = QI;
  int retry_exp = 0;
  int outcome   = 0;   // 0 success, 1 retry, 2 fail
  int hist[4];

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];   // expected slot offsets, one per draw
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in the DRAW cycle: the slot offset is the LFSR value modulo 2^Q.
  task automatic draw_model();
    logic [15:0] r;
    r = 16'(int'(m_lfsr) % (1 << q_exp));
    exp_q.push_back(r);
    if (q_exp == 2) hist[r[1:0]]++;
  endtask

  task automatic start_req();
    bus.req = 1'b1;
    cyc();
    bus.req = 1'b0;
    chk("req_busy", 16'(bus.busy), 16'd1);
    draw_model();
    cyc();
  endtask

  // Issue slot ticks with random gaps until mod_start; expect it after R+1 ticks.
  task automatic wait_slot();
    logic [15:0] r;
    int ticks = 0;
    bit got = 0;
    bit early = 0;
    r = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    while (!got && ticks < 200) begin
      repeat ($urandom_range(0, 2)) begin
        bus.req = 1'($urandom_range(0, 1));   // must be ignored while busy
        cyc();
        bus.req = 1'b0;
        if (bus.mod_start) early = 1;
      end
      bus.slot_tick = 1'b1;
      cyc();
      bus.slot_tick = 1'b0;
      ticks++;
      if (bus.mod_start) got = 1;
    end
    chk("no_early_start", 16'(early), 16'd0);
    chk("slot_ticks", 16'(ticks), r + 16'd1);
  endtask

  // Currently in the first TX cycle; hold mod_busy for k cycles after it.
  task automatic tx(input int k);
    bus.mod_busy = 1'b1;
    cyc();
    chk("start_width", 16'(bus.mod_start), 16'd0);
    repeat (k) cyc();
    bus.mod_busy = 1'b0;
    cyc();
    chk("tx_busy", 16'(bus.busy), 16'd1);
  endtask

  // Slot ticks in WAIT_FB that must not yet time out.
  task automatic tick_idle(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      bus.slot_tick = 1'b1;
      cyc();
      bus.slot_tick = 1'b0;
      chk("fbwait_busy", 16'(bus.busy), 16'd1);
      chk("fbwait_retry", 16'(bus.retry_cnt), 16'(retry_exp));
    end
  endtask

  task automatic feedback(input bit use_fb, input bit ack, input bit tick);
    bit exp_done, exp_fail;
    bus.fb_valid  = use_fb;
    bus.fb_ack    = ack;
    bus.slot_tick = tick;
    cyc();
    bus.fb_valid  = 1'b0;
    bus.fb_ack    = 1'b0;
    bus.slot_tick = 1'b0;
    exp_done = 0;
    exp_fail = 0;
    if (use_fb && ack) begin
      exp_done  = 1;
      q_exp     = (q_exp > QMIN) ? q_exp - 1 : QMIN;
      retry_exp = 0;
      outcome   = 0;
    end else begin
      q_exp = (q_exp < QMAX) ? q_exp + 1 : QMAX;
      if (retry_exp + 1 == MAXR) begin
        exp_fail  = 1;
        retry_exp = 0;
        outcome   = 2;
      end else begin
        retry_exp++;
        outcome = 1;
      end
    end
    chk("done", 16'(bus.done), 16'(exp_done));
    chk("fail", 16'(bus.fail), 16'(exp_fail));
    chk("q_cur", 16'(bus.q_cur), 16'(q_exp));
    chk("retry_cnt", 16'(bus.retry_cnt), 16'(retry_exp));
    chk("fb_busy", 16'(bus.busy), (outcome == 1) ? 16'd1 : 16'd0);
    if (outcome == 1) draw_model();
    cyc();
    chk("done_width", 16'(bus.done), 16'd0);
    chk("fail_width", 16'(bus.fail), 16'd0);
  endtask

  // policy: 0 ack, 1 nack, 2 timeout, 3 random biased towards Q=2
  task automatic run_request(input int policy);
    int att = 0;
    int mode;
    start_req();
    outcome = 1;
    while (outcome == 1 && att < MAXR + 1) begin
      wait_slot();
      tx($urandom_range(0, 3));
      mode = policy;
      if (policy == 3) begin
        if (q_exp < 2)      mode = 1;
        else if (q_exp > 2) mode = 0;
        else                mode = $urandom_range(0, 2);
      end
      if (mode == 0)      feedback(1, 1, 0);
      else if (mode == 1) feedback(1, 0, 0);
      else begin
        tick_idle(FBT - 1);
        feedback(0, 0, 1);
      end
      att++;
    end
    chk("request_ended", (outcome == 1) ? 16'd1 : 16'd0, 16'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.enable = 1'b1; bus.req = 1'b0; bus.slot_tick = 1'b0;
    bus.mod_busy = 1'b0; bus.fb_valid = 1'b0; bus.fb_ack = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mod_start", 16'(bus.mod_start), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_fail", 16'(bus.fail), 16'd0);
    chk("rst_q", 16'(bus.q_cur), 16'(QI));
    chk("rst_retry", 16'(bus.retry_cnt), 16'd0);
    rst_n = 1'b1;
    cyc();

    // Successes walk Q down 2 -> 1 -> 0.
    run_request(0);
    run_request(0);

    // Q=0: offset is always 0, so mod_start follows the first tick.
    start_req();
    repeat (5) cyc();
    wait_slot();
    tx(10);
    feedback(1, 1, 0);
    chk("q_floor", 16'(bus.q_cur), 16'd0);
    repeat (4) begin
      cyc();
      chk("idle_no_start", 16'(bus.mod_start), 16'd0);
    end

    // Timeout on the FB_TIMEOUT-th tick, then ack that coincides with that tick.
    start_req();
    wait_slot();
    tx(2);
    tick_idle(FBT - 1);
    feedback(0, 0, 1);
    wait_slot();
    tx(1);
    tick_idle(FBT - 1);
    feedback(1, 1, 1);

    // Nack every attempt: Q saturates at Q_MAX, fail on the last attempt.
    run_request(1);
    chk("fail_outcome", 16'(outcome), 16'd2);
    repeat (10) begin
      bus.slot_tick = 1'b1;
      cyc();
      bus.slot_tick = 1'b0;
      chk("no_start_after_fail", 16'(bus.mod_start), 16'd0);
    end
    chk("idle_after_fail", 16'(bus.busy), 16'd0);

    // enable low in WAIT_SLOT with a retry pending.
    start_req();
    wait_slot();
    tx(0);
    feedback(1, 0, 0);
    bus.enable = 1'b0;
    cyc();
    retry_exp = 0;
    exp_q.delete();
    chk("en_busy", 16'(bus.busy), 16'd0);
    chk("en_q", 16'(bus.q_cur), 16'(q_exp));
    chk("en_retry", 16'(bus.retry_cnt), 16'd0);
    repeat (5) begin
      bus.slot_tick = 1'b1;
      cyc();
      bus.slot_tick = 1'b0;
      chk("en_no_start", 16'(bus.mod_start), 16'd0);
    end
    bus.enable = 1'b1;
    cyc();

    // Randomised traffic.
    for (int i = 0; i < 200; i++) run_request(3);

    // Asynchronous reset while the start pulse is on the wire.
    start_req();
    wait_slot();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mod_start", 16'(bus.mod_start), 16'd0);
    chk("arst_busy", 16'(bus.busy), 16'd0);
    chk("arst_done", 16'(bus.done), 16'd0);
    chk("arst_fail", 16'(bus.fail), 16'd0);
    chk("arst_q", 16'(bus.q_cur), 16'(QI));
    chk("arst_retry", 16'(bus.retry_cnt), 16'd0);
    q_exp = QI;
    retry_exp = 0;
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    cyc();
    run_request(0);

    for (int b = 0; b < 4; b++) chk("hist_bin", (hist[b] > 0) ? 16'd1 : 16'd0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
